// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack-machine sequencer: opcodes, ALU ops, error codes, states.
package stack_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_NOT   = 3'b011;
  localparam logic [2:0] OP_PUSHM = 3'b100;
  localparam logic [2:0] OP_POPM  = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_BRZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  typedef enum logic [3:0] {
    ST_IF, ST_DEC, ST_MRD, ST_PSHM, ST_POP1, ST_LDA, ST_MWR, ST_NOT,
    ST_POP2, ST_LDB, ST_ALU, ST_PSHR, ST_JMP, ST_BRZ, ST_TRAP
  } state_t;

  // add/sub/and consume two stack operands
  function automatic logic is_binop(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/stack_depth_cnt.sv
// Up/down stack occupancy counter with full/empty flags; saturates at 0 and DEPTH.
module stack_depth_cnt #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign full  = (cnt_q == MAX_CNT);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/stack_seq_ctrl.sv
// Multicycle control sequencer for a stack machine: Moore FSM decoding the IR opcode into
// datapath strobes, with a depth guard that traps on stack underflow/overflow.
module stack_seq_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OPW   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OPW-1:0]               opcode,
  input  logic                         mem_ready,
  output logic                         IorD,
  output logic                         srcA,
  output logic                         srcB,
  output logic                         lda,
  output logic                         ldb,
  output logic                         PCsrc,
  output logic                         PCwrite,
  output logic                         PCwriteCond,
  output logic                         memRead,
  output logic                         memWrite,
  output logic                         IRwrite,
  output logic                         tos,
  output logic                         pop,
  output logic                         push,
  output logic                         MtoS,
  output logic [1:0]                   ALUop,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         trap,
  output logic [1:0]                   err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] TWO = CW'(2);

  state_t     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic [2:0] op;
  logic       full, empty;

  assign op = opcode[2:0];

  if (OPW > 3) begin : g_opcode_hi
    logic unused_opcode_hi;
    assign unused_opcode_hi = ^opcode[OPW-1:3];
  end

  stack_depth_cnt #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (push),
    .dec   (pop),
    .cnt   (depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IF:   if (mem_ready) state_d = ST_DEC;
      ST_DEC: begin
        // Operand availability is checked here so a faulting op never touches the stack
        case (op)
          OP_JMP:   state_d = ST_JMP;
          OP_BRZ:   state_d = ST_BRZ;
          OP_PUSHM: begin
            if (full) begin
              state_d = ST_TRAP;
              err_d   = ERR_OVER;
            end else begin
              state_d = ST_MRD;
            end
          end
          default: begin
            if ((is_binop(op) && (depth < TWO)) || (!is_binop(op) && empty)) begin
              state_d = ST_TRAP;
              err_d   = ERR_UNDER;
            end else begin
              state_d = ST_POP1;
            end
          end
        endcase
      end
      ST_MRD:  if (mem_ready) state_d = ST_PSHM;
      ST_PSHM: state_d = ST_IF;
      ST_POP1: state_d = ST_LDA;
      ST_LDA: begin
        if (op == OP_POPM)     state_d = ST_MWR;
        else if (op == OP_NOT) state_d = ST_NOT;
        else                   state_d = ST_POP2;
      end
      ST_MWR:  if (mem_ready) state_d = ST_IF;
      ST_NOT:  state_d = ST_PSHR;
      ST_POP2: state_d = ST_LDB;
      ST_LDB:  state_d = ST_ALU;
      ST_ALU:  state_d = ST_PSHR;
      ST_PSHR: state_d = ST_IF;
      ST_JMP:  state_d = ST_IF;
      ST_BRZ:  state_d = ST_IF;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IF;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    IorD        = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    lda         = 1'b0;
    ldb         = 1'b0;
    PCsrc       = 1'b0;
    PCwrite     = 1'b0;
    PCwriteCond = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRwrite     = 1'b0;
    tos         = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    MtoS        = 1'b0;
    ALUop       = ALU_ADD;
    case (state_q)
      ST_IF: begin
        // PC+1 and IR load both land on the cycle the fetch completes
        memRead = 1'b1;
        PCwrite = mem_ready;
        IRwrite = mem_ready;
      end
      ST_DEC:  tos = 1'b1;
      ST_MRD: begin
        IorD    = 1'b1;
        memRead = 1'b1;
      end
      ST_PSHM: begin
        MtoS = 1'b1;
        push = 1'b1;
      end
      ST_POP1, ST_POP2: pop = 1'b1;
      ST_LDA:  lda = 1'b1;
      ST_LDB:  ldb = 1'b1;
      ST_MWR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
      end
      ST_NOT:  ALUop = ALU_NOT;
      ST_ALU:  ALUop = op[1:0];
      ST_PSHR: push = 1'b1;
      ST_JMP: begin
        PCsrc   = 1'b1;
        PCwrite = 1'b1;
      end
      ST_BRZ: begin
        PCsrc       = 1'b1;
        PCwriteCond = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap = (state_q == ST_TRAP);
  assign err  = err_q;

endmodule

// File: doc/stack_seq_ctrl.md
STACK_SEQ_CTRL -- requirements
Module: stack_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, is the stack capacity in entries (legal range 2..256).
REQ-002 Parameter OPW, default 3, is the opcode width; only opcode[2:0] is decoded and upper bits are ignored.
REQ-003 Ports: clk in 1 (clock); rst in 1 (asynchronous, active-high reset); opcode in OPW (current IR opcode); mem_ready in 1 (memory completes the access this cycle).
REQ-004 Datapath strobes, all out 1: IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, PCwriteCond, memRead, memWrite, IRwrite, tos, pop, push, MtoS.
REQ-005 Other outputs: ALUop out 2 (00 add, 01 sub, 10 and, 11 not); depth out $clog2(DEPTH+1) (current stack occupancy); trap out 1 (sticky fault); err out 2 (00 none, 01 underflow, 10 overflow).

Function
REQ-006 Opcodes: 000 add, 001 sub, 010 and, 011 not, 100 push-from-mem, 101 pop-to-mem, 110 jump, 111 branch-if-zero.
REQ-007 One-hot-free encoded Moore FSM; states: IF, DEC, MRD, PSHM, POP1, LDA, MWR, NOT, POP2, LDB, ALU, PSHR, JMP, BRZ, TRAP.
REQ-008 All strobes are 0 and ALUop is 00 in every state unless listed below.
REQ-009 IF: memRead=1; IorD=srcA=srcB=0; ALUop=00; PCsrc=0; PCwrite=IRwrite=mem_ready; stays in IF while mem_ready=0; goes to DEC when mem_ready=1.
REQ-010 DEC: tos=1; next state is JMP (110), BRZ (111), MRD (100), POP1 (000-011, 101), unless REQ-017 forces TRAP.
REQ-011 MRD: IorD=1, memRead=1; holds while mem_ready=0; goes to PSHM when mem_ready=1.
REQ-012 PSHM: MtoS=1, push=1; goes to IF.
REQ-013 POP1: pop=1 -> LDA. LDA: lda=1 -> MWR (101), NOT (011), otherwise POP2.
REQ-014 MWR: IorD=1, memWrite=1; holds while mem_ready=0; goes to IF when mem_ready=1.
REQ-015 NOT: ALUop=11 -> PSHR. POP2: pop=1 -> LDB. LDB: ldb=1 -> ALU. ALU: ALUop=opcode[1:0] -> PSHR. PSHR: push=1 -> IF.
REQ-016 JMP: PCsrc=PCwrite=1 -> IF. BRZ: PCsrc=PCwriteCond=1 -> IF.
REQ-017 Depth check in DEC: binary ALU op with depth<2 -> err=01; not or pop-to-mem with depth<1 -> err=01; push-from-mem with depth==DEPTH -> err=10; any violation -> TRAP with no pop/push issued.
REQ-018 The depth counter increments on every push cycle and decrements on every pop cycle; it never wraps, and this is guaranteed by REQ-017.
REQ-019 TRAP: trap=1, all strobes 0, err held; TRAP is absorbing until rst.
REQ-020 An opcode change in the middle of an instruction affects only the states that decode it (DEC, LDA, ALU); this follows IR semantics.

Reset
REQ-021 rst asserted at any time forces state IF, depth=0, err=00, trap=0 asynchronously; all strobes take their IF values, with PCwrite=IRwrite=mem_ready.
REQ-022 Reset asserted during MRD or MWR abandons the access; no push or pop occurs.

Structure
REQ-023 A shared package stack_ctrl_pkg holds the opcode constants, the ALUop constants, the err codes, and the state enum typedef.
REQ-024 One sub-module, stack_depth_cnt (a parametrised up/down occupancy counter with a full/empty compare), is instantiated; everything else is one FSM with a next-state block and an output block.

Verification
REQ-025 Reset with mem_ready=1, then opcode=100 with mem_ready low for 3 cycles in MRD -> MRD held 4 cycles, one push, depth=1, back to IF.
REQ-026 Two push-from-mem, then opcode=001 -> sequence POP1, LDA, POP2, LDB, ALU (ALUop=01), PSHR; depth goes 2->0->1.
REQ-027 depth=0 and opcode=000 -> DEC then TRAP, err=01, trap=1, no pop, state stays TRAP for 10 cycles until rst.
REQ-028 DEPTH=2: three push-from-mem -> third traps at DEC with err=10 and depth=2.
REQ-029 opcode=110 -> IF, DEC, JMP with PCsrc=PCwrite=1; opcode=111 -> BRZ with PCwriteCond=1 and PCwrite=0.
REQ-030 rst pulsed in the middle of a cycle during MWR -> outputs show IF values immediately, depth=0, memWrite=0.
